fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream consumer of the 16-deep synchronous byte FIFO. It pops one byte at a time
//  through the FIFO read port and serialises it as an asynchronous UART frame on tx:
//  start bit, DATA_W data bits LSB first, optional parity, one stop bit.
//  It drains the FIFO continuously while enabled and the FIFO is non-empty.
// PARAMETERS
//  DATA_W        8   data bits per frame; must equal the FIFO word width
//  CLKS_PER_BIT  16  clk cycles per UART bit; >=2; counter width $clog2(CLKS_PER_BIT)
//  PARITY_EN     0   1 inserts a parity bit after the data bits
//  PARITY_ODD    0   parity sense when PARITY_EN=1 (0 = even, 1 = odd)
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  rst           in   1       asynchronous, active-low reset
//  tx_en         in   1       1 = allowed to start new frames; 0 = finish current frame, then idle
//  fifo_empty    in   1       FIFO empty flag
//  fifo_wr_en    in   1       FIFO write strobe (monitor only; the FIFO drops reads while it is 1)
//  fifo_rd_data  in   DATA_W  FIFO registered read data, valid the cycle after an accepted read
//  fifo_rd_en    out  1       FIFO read request
//  tx            out  1       serial line, idle high
//  busy          out  1       1 in any state other than IDLE
//  frame_done    out  1       one-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0,
//   shift reg=0, bit/baud counters=0. A reset mid-frame drives tx high immediately.
//   The partial frame is abandoned; the popped byte is lost.
//  FSM states and transitions:
//   IDLE  : tx=1. Go to FETCH when tx_en && !fifo_empty.
//   FETCH : fifo_rd_en=1 (Moore output). The read is accepted only on a cycle with fifo_wr_en=0.
//           If fifo_wr_en=1, stay in FETCH and hold fifo_rd_en. Otherwise go to WAIT.
//   WAIT  : fifo_rd_en=0. At the end of this cycle, latch fifo_rd_data into the shift register
//           and compute parity = ^data ^ PARITY_ODD. Go to START.
//   START : tx=0 for CLKS_PER_BIT cycles, then DATA.
//   DATA  : tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
//           After DATA_W bits go to PARITY if PARITY_EN, else STOP.
//   PARITY: tx=parity bit for CLKS_PER_BIT cycles, then STOP.
//   STOP  : tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle. Then IDLE.
//  Timing:
//   - tx, busy and frame_done are registered outputs: no combinational path from inputs.
//   - Latency with fifo_wr_en=0: IDLE sees !fifo_empty at cycle 0, fifo_rd_en=1 at cycle 1,
//     data latched at end of cycle 2, tx falls at cycle 3.
//   - Frame length: (1+DATA_W+PARITY_EN+1)*CLKS_PER_BIT cycles, start through stop.
//   - Back-to-back frames: the idle-high gap between stop and the next start is 3 cycles.
//  Boundaries:
//   - tx_en falling mid-frame: the frame completes normally and no new FETCH is issued.
//   - tx_en falling while in FETCH: the FETCH still completes, so the read is never withdrawn.
//   - fifo_empty is sampled only in IDLE. One read per frame, so the FIFO is never over-read.
//   - Baud counter runs 0..CLKS_PER_BIT-1 and wraps. The bit counter counts 0..DATA_W-1.
//   - No counter is allowed to overflow into an undefined state.
//   - Illegal or unused state encodings return to IDLE on the next clock.
// TESTING
//  1. CLKS_PER_BIT=4, PARITY_EN=0, push 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1; each bit lasts
//     4 clk; frame 40 clk; frame_done=1 for 1 cycle; exactly 1 fifo_rd_en pulse.
//  2. Push 0x01,0x02,0x03 back-to-back -> 3 frames, gaps of 3 idle-high cycles between them,
//     bytes serialised in order, fifo_empty=1 afterwards.
//  3. Hold fifo_wr_en=1 for 5 cycles during FETCH -> fifo_rd_en stays high for 6 cycles;
//     the byte is transmitted correctly and not duplicated.
//  4. PARITY_EN=1, PARITY_ODD=0, push 0x07 -> parity bit=1; PARITY_ODD=1 -> parity bit=0;
//     frame 44 clk at CLKS_PER_BIT=4.
//  5. Drop tx_en in the middle of DATA with 2 bytes queued -> current frame completes,
//     no further fifo_rd_en, busy=0; re-assert tx_en -> 2nd byte is sent.
//  6. Assert rst=0 during bit 4 of a frame -> tx=1, busy=0 and fifo_rd_en=0 the same cycle
//     (async); after release the block idles until fifo_empty=0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes one at a time from a synchronous FIFO and serialises each one
// as an asynchronous UART frame on tx. A frame is a start bit, DATA_W data
// bits LSB first, an optional parity bit, and one stop bit. The block keeps
// draining the FIFO while tx_en is high and the FIFO is not empty.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   tx_en        in   1 = new frames may start; 0 = finish current frame, then idle
//   fifo_empty   in   FIFO empty flag, looked at only in IDLE
//   fifo_wr_en   in   FIFO write strobe; the FIFO ignores reads while it is high
//   fifo_rd_data in   FIFO registered read data, valid the cycle after a read
//   fifo_rd_en   out  FIFO read request, high for the whole FETCH state
//   tx           out  serial line, idle high, registered
//   busy         out  high in every state except IDLE, registered
//   frame_done   out  one-cycle pulse on the last cycle of the stop bit, registered
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic              fifo_wr_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic PAR_ON  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        bit_end  = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_en && !fifo_empty) state_d = S_FETCH;
            end
            // The FIFO drops reads during writes, so the request is held until
            // a write-free cycle; tx_en is deliberately ignored here.
            S_FETCH: begin
                if (!fifo_wr_en) state_d = S_WAIT;
            end
            S_WAIT: begin
                shift_d  = fifo_rd_data;
                parity_d = (^fifo_rd_data) ^ PAR_ODD;
                state_d  = S_START;
            end
            S_START: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PAR_ON ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs are computed from next-state values so that they
        // line up with the state they describe, with no input-to-output path.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    end

    assign fifo_rd_en = (state_q == S_FETCH);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Three instances (no parity, even parity, odd parity) share one FIFO model;
// only the instance picked by sel sees a non-empty FIFO. Each sampled cycle is
// packed as {tx, busy, frame_done, fifo_rd_en} and compared with a timeline
// built from the frame format and the documented latencies.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_en;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    int            sel;
    logic          empty0, empty1, empty2;
    logic          rd0, rd1, rd2, tx0, tx1, tx2;
    logic          bz0, bz1, bz2, dn0, dn1, dn2;
    logic          tx_s, busy_s, done_s, rd_s;

    int errors = 0;
    int checks = 0;

    logic [3:0] cap  [$];
    logic [3:0] expw [$];
    logic [7:0] mdl_bytes [$];
    int         mdl_stall [$];
    logic [7:0] pq [$];

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty0), .fifo_wr_en(wr_en),
        .fifo_rd_data(rd_data), .fifo_rd_en(rd0), .tx(tx0), .busy(bz0), .frame_done(dn0));
    fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty1), .fifo_wr_en(wr_en),
        .fifo_rd_data(rd_data), .fifo_rd_en(rd1), .tx(tx1), .busy(bz1), .frame_done(dn1));
    fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty2), .fifo_wr_en(wr_en),
        .fifo_rd_data(rd_data), .fifo_rd_en(rd2), .tx(tx2), .busy(bz2), .frame_done(dn2));

    always_comb begin
        tx_s = tx0; busy_s = bz0; done_s = dn0; rd_s = rd0;
        if (sel == 1) begin
            tx_s = tx1; busy_s = bz1; done_s = dn1; rd_s = rd1;
        end else if (sel == 2) begin
            tx_s = tx2; busy_s = bz2; done_s = dn2; rd_s = rd2;
        end
    end

    // 16-deep FIFO: writes win, reads during a write are dropped.
    logic [7:0] fmem [16];
    int fwp, frp, fcnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwp <= 0; frp <= 0; fcnt <= 0; rd_data <= '0;
        end else if (wr_en) begin
            if (fcnt < 16) begin
                fmem[fwp] <= wr_data; fwp <= (fwp + 1) % 16; fcnt <= fcnt + 1;
            end
        end else if (rd_s && fcnt > 0) begin
            rd_data <= fmem[frp]; frp <= (frp + 1) % 16; fcnt <= fcnt - 1;
        end
    end
    assign empty0 = (sel != 0) || (fcnt == 0);
    assign empty1 = (sel != 1) || (fcnt == 0);
    assign empty2 = (sel != 2) || (fcnt == 0);

    task automatic sample();
        @(negedge clk);
        cap.push_back({tx_s, busy_s, done_s, rd_s});
    endtask

    task automatic run(input int n);
        repeat (n) sample();
    endtask

    task automatic push_all();
        for (int i = 0; i < pq.size(); i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = pq[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic mdl_cyc(input logic t, input logic b, input logic d, input logic r);
        expw.push_back({t, b, d, r});
    endtask

    // Timeline from the first FETCH cycle: FETCH (plus stalls), WAIT, the frame
    // bits each CPB cycles long, and one IDLE cycle before the next FETCH.
    task automatic build_model(input int par_en, input int par_odd, input int len);
        logic [7:0] v;
        logic       fb [$];
        expw.delete();
        for (int k = 0; k < mdl_bytes.size(); k++) begin
            v = mdl_bytes[k];
            if (k > 0) mdl_cyc(1'b1, 1'b0, 1'b0, 1'b0);
            for (int s = 0; s <= mdl_stall[k]; s++) mdl_cyc(1'b1, 1'b1, 1'b0, 1'b1);
            mdl_cyc(1'b1, 1'b1, 1'b0, 1'b0);
            fb.delete();
            fb.push_back(1'b0);
            for (int i = 0; i < DW; i++) fb.push_back(v[i]);
            if (par_en != 0) fb.push_back((^v) ^ (par_odd != 0));
            fb.push_back(1'b1);
            for (int b = 0; b < fb.size(); b++)
                for (int c = 0; c < CPB; c++)
                    mdl_cyc(fb[b], 1'b1, (b == fb.size() - 1) && (c == CPB - 1), 1'b0);
        end
        while (expw.size() < len) mdl_cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_mdl1(input logic [7:0] b, input int stall);
        mdl_bytes.delete(); mdl_stall.delete();
        mdl_bytes.push_back(b); mdl_stall.push_back(stall);
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_en = 1'b0; wr_en = 1'b0; wr_data = '0; sel = 0;
        #2 rst = 1'b0;
        #1;
        checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_s); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_s); end
        checks++; if (rd_s !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_s); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int nbad, fidx, st, dn, ndn, nrd, idx;
        logic [9:0] obs;
        sel = 0; tx_en = 1'b1;
        pq.delete(); pq.push_back(8'hA5); push_all();
        cap.delete(); run(50);
        set_mdl1(8'hA5, 0); build_model(0, 0, 50);
        nbad = 0; fidx = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL single_wave: %0d bad cycles, first %0d got %b want %b", nbad, fidx, cap[fidx], expw[fidx]); end
        st = -1; dn = -1; ndn = 0; nrd = 0;
        for (int i = 0; i < cap.size(); i++) begin
            if (st < 0 && cap[i][3] == 1'b0) st = i;
            if (cap[i][1] === 1'b1) begin ndn++; if (dn < 0) dn = i; end
            if (cap[i][0] === 1'b1 && (i == 0 || cap[i-1][0] !== 1'b1)) nrd++;
        end
        for (int b = 0; b < 10; b++) begin
            idx = st + b * CPB + 2;
            obs[b] = (st >= 0 && idx < cap.size()) ? cap[idx][3] : 1'bx;
        end
        checks++; if (st !== 2) begin errors++; $display("FAIL single_latency: start idx %0d want 2", st); end
        checks++; if (obs !== 10'b1101001010) begin errors++; $display("FAIL single_bits: got %b want 1101001010", obs); end
        checks++; if (dn - st + 1 !== 40) begin errors++; $display("FAIL single_len: got %0d want 40", dn - st + 1); end
        checks++; if (ndn !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", ndn); end
        checks++; if (nrd !== 1) begin errors++; $display("FAIL single_rd_cnt: got %0d want 1", nrd); end
    endtask

    task automatic test_back_to_back();
        int nbad, fidx, dn, st2;
        for (int r = 0; r < 2; r++) begin
            sel = 0; tx_en = 1'b0;
            mdl_bytes.delete(); mdl_stall.delete(); pq.delete();
            for (int k = 0; k < 3; k++) begin
                pq.push_back((r == 0) ? 8'(k + 1) : 8'($urandom));
                mdl_bytes.push_back(pq[k]); mdl_stall.push_back(0);
            end
            push_all();
            tx_en = 1'b1;
            cap.delete(); run(134);
            build_model(0, 0, 134);
            nbad = 0; fidx = 0;
            for (int i = 0; i < cap.size(); i++)
                if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
            checks++;
            if (nbad != 0) begin errors++; $display("FAIL b2b_wave%0d: %0d bad cycles, first %0d got %b want %b", r, nbad, fidx, cap[fidx], expw[fidx]); end
        end
        dn = -1; st2 = -1;
        for (int i = 0; i < cap.size(); i++) begin
            if (dn < 0 && cap[i][1] === 1'b1) dn = i;
            if (dn >= 0 && st2 < 0 && cap[i][3] === 1'b0) st2 = i;
        end
        checks++; if (st2 - dn - 1 !== 3) begin errors++; $display("FAIL b2b_gap: got %0d want 3", st2 - dn - 1); end
        checks++; if (fcnt !== 0) begin errors++; $display("FAIL b2b_empty: fifo count %0d want 0", fcnt); end
    endtask

    task automatic test_fetch_stall();
        int nbad, fidx, nrun;
        logic [7:0] a;
        logic [7:0] bq [$];
        sel = 0; tx_en = 1'b1;
        a = 8'($urandom);
        pq.delete(); pq.push_back(a); push_all();
        cap.delete(); sample();
        for (int j = 0; j < 5; j++) begin
            bq.push_back(8'($urandom));
            wr_en = 1'b1; wr_data = bq[j];
            sample();
        end
        wr_en = 1'b0;
        run(261);
        set_mdl1(a, 5);
        for (int j = 0; j < 5; j++) begin mdl_bytes.push_back(bq[j]); mdl_stall.push_back(0); end
        build_model(0, 0, 267);
        nbad = 0; fidx = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL stall_wave: %0d bad cycles, first %0d got %b want %b", nbad, fidx, cap[fidx], expw[fidx]); end
        nrun = 0;
        while (nrun < cap.size() && cap[nrun][0] === 1'b1) nrun++;
        checks++; if (nrun !== 6) begin errors++; $display("FAIL stall_rd_len: got %0d want 6", nrun); end
    endtask

    task automatic test_parity();
        int nbad, fidx, st, dn;
        logic [7:0] rb;
        logic pbit;
        for (int s = 1; s <= 2; s++) begin
            sel = s; tx_en = 1'b0;
            rb = 8'($urandom);
            pq.delete(); pq.push_back(8'h07); pq.push_back(rb); push_all();
            tx_en = 1'b1;
            cap.delete(); run(98);
            set_mdl1(8'h07, 0); mdl_bytes.push_back(rb); mdl_stall.push_back(0);
            build_model(1, s - 1, 98);
            nbad = 0; fidx = 0;
            for (int i = 0; i < cap.size(); i++)
                if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
            checks++;
            if (nbad != 0) begin errors++; $display("FAIL parity_wave%0d: %0d bad cycles, first %0d got %b want %b", s, nbad, fidx, cap[fidx], expw[fidx]); end
            st = -1; dn = -1;
            for (int i = 0; i < cap.size(); i++) begin
                if (st < 0 && cap[i][3] === 1'b0) st = i;
                if (dn < 0 && cap[i][1] === 1'b1) dn = i;
            end
            pbit = (st >= 0) ? cap[st + 9 * CPB + 2][3] : 1'bx;
            checks++; if (pbit !== ((s == 1) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL parity_bit%0d: got %b want %b", s, pbit, (s == 1)); end
            checks++; if (dn - st + 1 !== 44) begin errors++; $display("FAIL parity_len%0d: got %0d want 44", s, dn - st + 1); end
        end
        sel = 0;
    endtask

    task automatic test_tx_en_drop();
        int nbad, fidx;
        logic [7:0] b0, b1;
        sel = 0; tx_en = 1'b0;
        b0 = 8'($urandom); b1 = 8'($urandom);
        pq.delete(); pq.push_back(b0); pq.push_back(b1); push_all();
        tx_en = 1'b1;
        cap.delete();
        for (int i = 0; i < 60; i++) begin
            sample();
            if (i == 18) tx_en = 1'b0;
        end
        set_mdl1(b0, 0); build_model(0, 0, 60);
        nbad = 0; fidx = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL txen_drop_wave: %0d bad cycles, first %0d got %b want %b", nbad, fidx, cap[fidx], expw[fidx]); end
        checks++; if (fcnt !== 1) begin errors++; $display("FAIL txen_drop_left: fifo count %0d want 1", fcnt); end
        tx_en = 1'b1;
        cap.delete(); run(45);
        set_mdl1(b1, 0); build_model(0, 0, 45);
        nbad = 0; fidx = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL txen_resume_wave: %0d bad cycles, first %0d got %b want %b", nbad, fidx, cap[fidx], expw[fidx]); end
    endtask

    task automatic test_mid_reset();
        int nbad, fidx;
        logic [7:0] v;
        sel = 0; tx_en = 1'b1;
        v = 8'($urandom) & 8'hEF;
        pq.delete(); pq.push_back(v); push_all();
        cap.delete(); run(24);
        set_mdl1(v, 0); build_model(0, 0, 24);
        nbad = 0; fidx = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL rst_pre_wave: %0d bad cycles, first %0d got %b want %b", nbad, fidx, cap[fidx], expw[fidx]); end
        rst = 1'b0;
        #1;
        checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b want 1", tx_s); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy_s); end
        checks++; if (rd_s !== 1'b0) begin errors++; $display("FAIL rst_async_rd_en: got %b want 0", rd_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL rst_async_done: got %b want 0", done_s); end
        @(negedge clk);
        rst = 1'b1;
        cap.delete(); run(20);
        mdl_bytes.delete(); mdl_stall.delete(); build_model(0, 0, 20);
        nbad = 0; fidx = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL rst_idle_wave: %0d bad cycles, first %0d got %b want %b", nbad, fidx, cap[fidx], expw[fidx]); end
        v = 8'($urandom);
        pq.delete(); pq.push_back(v); push_all();
        cap.delete(); run(44);
        set_mdl1(v, 0); build_model(0, 0, 44);
        nbad = 0; fidx = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== expw[i]) begin if (nbad == 0) fidx = i; nbad++; end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL rst_recover_wave: %0d bad cycles, first %0d got %b want %b", nbad, fidx, cap[fidx], expw[fidx]); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fetch_stall();
        test_parity();
        test_tx_en_drop();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
